// File: rtl/apb_master_ctrl.sv
// APB requester: takes single read/write commands on a valid/ready port, decodes one of three
// peripheral selects, runs SETUP/ACCESS with a bounded wait, and returns a one-cycle response.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    output logic [1:0]        fsm_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready
    // never looks at cmd_valid. Responses are single-cycle pulses with no backpressure.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic [2:0]          sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;
    logic [7:0]          wait_cnt;
    logic                err_pending;

    logic [2:0]          dec_sel;
    logic                accept;
    logic                rsp_set;
    logic                rsp_err_set;
    logic [DATA_W-1:0]   rsp_rdata_set;
    logic                pending_set;

    always_comb begin
        dec_sel = 3'b000;
        case (cmd_addr[ADDR_W-1 -: 6])
            6'b100000: dec_sel = 3'b001;
            6'b100001: dec_sel = 3'b010;
            6'b100010: dec_sel = 3'b100;
            default:   dec_sel = 3'b000;
        endcase
    end

    assign cmd_ready = ((state == IDLE) && !err_pending) || ((state == ACCESS) && Pready);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_next    = state;
        rsp_set       = 1'b0;
        rsp_err_set   = 1'b0;
        rsp_rdata_set = '0;
        pending_set   = 1'b0;
        case (state)
            IDLE: begin
                if (err_pending) begin
                    rsp_set     = 1'b1;
                    rsp_err_set = 1'b1;
                end else if (accept) begin
                    if (dec_sel != 3'b000) begin
                        state_next = SETUP;
                    end else begin
                        rsp_set     = 1'b1;
                        rsp_err_set = 1'b1;
                    end
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (Pready) begin
                    rsp_set       = 1'b1;
                    rsp_rdata_set = write_q ? '0 : Prdata;
                    state_next    = IDLE;
                    // A bad back-to-back command owes an error response one cycle after this one.
                    if (accept) begin
                        if (dec_sel != 3'b000) state_next = SETUP;
                        else                   pending_set = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    rsp_set     = 1'b1;
                    rsp_err_set = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state       <= IDLE;
            sel_q       <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            wait_cnt    <= 8'd0;
            err_pending <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_next;
            err_pending <= pending_set;
            rsp_valid   <= rsp_set;
            rsp_err     <= rsp_err_set;
            rsp_rdata   <= rsp_rdata_set;
            if (accept) begin
                sel_q   <= dec_sel;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                write_q <= cmd_write;
            end
            if (state_next == SETUP) begin
                wait_cnt <= 8'd0;
            end else if ((state == ACCESS) && !Pready && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign Pselx     = ((state == SETUP) || (state == ACCESS)) ? sel_q : 3'b000;
    assign Penable   = (state == ACCESS);
    assign Pwrite    = write_q;
    assign Paddr     = addr_q;
    assign Pwdata    = wdata_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed scenarios plus randomized commands checked against a
// transaction-level model of decode, wait/timeout and response timing.
module tb_apb_master_ctrl;

    localparam int TIMEOUT = 16;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .Hclk(Hclk), .Hreset(Hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata(Prdata), .Pready(Pready), .fsm_state(fsm_state)
    );

    always #5 Hclk = ~Hclk;

    // Reference model: address map as numeric ranges of the top byte.
    function automatic logic [2:0] model_sel(input logic [31:0] a);
        int b;
        b = int'(a[31:24]);
        if (b >= 8'h80 && b <= 8'h83) return 3'b001;
        if (b >= 8'h84 && b <= 8'h87) return 3'b010;
        if (b >= 8'h88 && b <= 8'h8B) return 3'b100;
        return 3'b000;
    endfunction

    // Issues one command from idle and observes the transfer; the peripheral holds Pready low
    // for nwait ACCESS cycles and then raises it. lat counts cycles after the accepting edge.
    task automatic do_txn(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input int nwait, input logic [31:0] prdata,
                          output int lat, output int n_setup, output int n_access,
                          output logic [2:0] sel_or, output logic [2:0] sel_at_rsp,
                          output int perr, output logic r_err, output logic [31:0] r_rdata);
        logic [2:0] first_sel;
        int acc;
        lat = -1; n_setup = 0; n_access = 0; sel_or = 3'b000; sel_at_rsp = 3'b000;
        perr = 0; r_err = 1'b0; r_rdata = '0; first_sel = 3'b000; acc = 0;
        @(posedge Hclk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_wdata = wdata;
        Prdata = prdata; Pready = 1'b0;
        @(negedge Hclk);
        if (cmd_ready !== 1'b1) perr++;
        @(posedge Hclk); #1;
        cmd_valid = 1'b0;
        for (int n = 1; n <= 300 && lat < 0; n++) begin
            @(negedge Hclk);
            if (Pselx !== 3'b000) begin
                if (first_sel == 3'b000) first_sel = Pselx;
                if (Pselx !== first_sel) perr++;
                sel_or = sel_or | Pselx;
                if (Paddr !== addr || Pwrite !== w) perr++;
                if (w && Pwdata !== wdata) perr++;
                if (Penable === 1'b1) begin
                    n_access++;
                    Pready = (acc >= nwait);
                    acc++;
                end else begin
                    n_setup++;
                end
            end else if (Penable !== 1'b0) begin
                perr++;
            end
            if (rsp_valid === 1'b1) begin
                lat = n; sel_at_rsp = Pselx; r_err = rsp_err; r_rdata = rsp_rdata;
            end
        end
        Pready = 1'b0;
    endtask

    task automatic test_reset();
        Hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        Prdata = '0; Pready = 1'b0;
        repeat (2) @(posedge Hclk);
        #1 Hreset = 1'b0;
        @(negedge Hclk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (Pselx !== 3'b000) begin errors++; $display("FAIL reset Pselx got=%b exp=000", Pselx); end
        checks++; if (Penable !== 1'b0) begin errors++; $display("FAIL reset Penable got=%b exp=0", Penable); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({rsp_err, rsp_rdata, Paddr, Pwdata, Pwrite} !== '0) begin
            errors++; $display("FAIL reset outputs not zero err=%b rdata=%h addr=%h wdata=%h", rsp_err, rsp_rdata, Paddr, Pwdata);
        end
    endtask

    task automatic test_write();
        int lat, ns, na, perr; logic [2:0] so, sr; logic e; logic [31:0] rd;
        do_txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h1234_5678, lat, ns, na, so, sr, perr, e, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL write latency got=%0d exp=3", lat); end
        checks++; if (so !== 3'b001 || ns !== 1 || na !== 1) begin
            errors++; $display("FAIL write phases sel=%b setup=%0d access=%0d exp=001/1/1", so, ns, na);
        end
        checks++; if (perr !== 0) begin errors++; $display("FAIL write apb_signals errors got=%0d exp=0", perr); end
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL write rsp err=%b rdata=%h exp=0/0", e, rd); end
    endtask

    task automatic test_wait_read();
        int lat, ns, na, perr; logic [2:0] so, sr; logic e; logic [31:0] rd;
        do_txn(1'b0, 32'h8400_0004, 32'h0, 3, 32'h0000_00A5, lat, ns, na, so, sr, perr, e, rd);
        checks++; if (na !== 4 || so !== 3'b010) begin errors++; $display("FAIL wait_read access=%0d sel=%b exp=4/010", na, so); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL wait_read latency got=%0d exp=6", lat); end
        checks++; if (rd !== 32'hA5 || e !== 1'b0) begin errors++; $display("FAIL wait_read rdata=%h err=%b exp=a5/0", rd, e); end
    endtask

    task automatic test_decode_error();
        int lat, ns, na, perr; logic [2:0] so, sr; logic e; logic [31:0] rd;
        do_txn(1'b0, 32'h9000_0000, 32'h0, 0, 32'hFFFF_FFFF, lat, ns, na, so, sr, perr, e, rd);
        checks++; if (so !== 3'b000 || ns !== 0 || na !== 0) begin errors++; $display("FAIL decode_err apb activity sel=%b", so); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL decode_err latency got=%0d exp=1", lat); end
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL decode_err rsp err=%b rdata=%h exp=1/0", e, rd); end
    endtask

    task automatic test_timeout();
        int lat, ns, na, perr; logic [2:0] so, sr; logic e; logic [31:0] rd;
        do_txn(1'b0, 32'h8800_0100, 32'h0, 1000, 32'h5555_AAAA, lat, ns, na, so, sr, perr, e, rd);
        checks++; if (na !== TIMEOUT) begin errors++; $display("FAIL timeout access cycles got=%0d exp=%0d", na, TIMEOUT); end
        checks++; if (lat !== 2 + TIMEOUT || sr !== 3'b000) begin
            errors++; $display("FAIL timeout rsp latency=%0d sel=%b exp=%0d/000", lat, sr, 2 + TIMEOUT);
        end
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout rsp err=%b rdata=%h exp=1/0", e, rd); end
    endtask

    task automatic test_random();
        logic [31:0] b_addr [5];
        int          b_wait [5];
        int lat, ns, na, perr, nwait, exp_lat, exp_acc;
        logic [2:0] so, sr, es; logic e, w, ok, to, exp_err; logic [31:0] rd, addr, wdata, prdata, exp_rd;
        logic [7:0] top;
        b_addr = '{32'h7FFF_FFFF, 32'h83FF_FFFF, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8C00_0000};
        b_wait = '{0, 15, 16, 1, 2};
        for (int i = 0; i < 45; i++) begin
            w = 1'($urandom_range(0, 1)); wdata = $urandom; prdata = $urandom;
            if (i < 5) begin
                addr = b_addr[i]; nwait = b_wait[i];
            end else begin
                top = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8'h80, 8'h8B));
                addr = {top, 24'($urandom)};
                nwait = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            end
            es = model_sel(addr);
            ok = (es != 3'b000);
            to = ok && (nwait >= TIMEOUT);
            exp_lat = !ok ? 1 : (to ? 2 + TIMEOUT : 3 + nwait);
            exp_acc = !ok ? 0 : (to ? TIMEOUT : nwait + 1);
            exp_err = !ok || to;
            exp_rd  = (ok && !to && !w) ? prdata : 32'h0;
            do_txn(w, addr, wdata, nwait, prdata, lat, ns, na, so, sr, perr, e, rd);
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand[%0d] latency addr=%h got=%0d exp=%0d", i, addr, lat, exp_lat); end
            checks++; if (so !== es || na !== exp_acc) begin
                errors++; $display("FAIL rand[%0d] phases addr=%h sel=%b access=%0d exp=%b/%0d", i, addr, so, na, es, exp_acc);
            end
            checks++; if (perr !== 0) begin errors++; $display("FAIL rand[%0d] apb_signals errors got=%0d exp=0", i, perr); end
            checks++; if (e !== exp_err || rd !== exp_rd) begin
                errors++; $display("FAIL rand[%0d] rsp err=%b rdata=%h exp=%b/%h", i, e, rd, exp_err, exp_rd);
            end
            @(negedge Hclk);
            checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
                errors++; $display("FAIL rand[%0d] rsp_pulse after valid=%b err=%b rdata=%h exp=0", i, rsp_valid, rsp_err, rsp_rdata);
            end
        end
    endtask

    // Two commands offered back to back with a zero-wait peripheral; second address given.
    task automatic run_b2b(input logic [31:0] addr2, output logic [2:0] sel_tr [1:7],
                           output logic en_tr [1:7], output logic rv_tr [1:7], output logic re_tr [1:7]);
        int accepts;
        accepts = 0;
        @(posedge Hclk); #1;
        Pready = 1'b1; Prdata = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8800_0000; cmd_wdata = 32'h1111_1111;
        @(negedge Hclk);
        if (cmd_ready === 1'b1) accepts++;
        @(posedge Hclk); #1;
        cmd_addr = addr2; cmd_wdata = 32'h2222_2222;
        for (int n = 1; n <= 7; n++) begin
            @(negedge Hclk);
            sel_tr[n] = Pselx; en_tr[n] = Penable; rv_tr[n] = rsp_valid; re_tr[n] = rsp_err;
            if (cmd_valid && cmd_ready === 1'b1) accepts++;
            @(posedge Hclk); #1;
            if (accepts >= 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0; Pready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] sel_tr [1:7]; logic en_tr [1:7]; logic rv_tr [1:7]; logic re_tr [1:7];
        logic [2:0] exp_sel [1:7]; logic exp_en [1:7]; logic exp_rv [1:7];
        int nrsp, last_err;
        exp_sel = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        exp_en  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        run_b2b(32'h8000_0000, sel_tr, en_tr, rv_tr, re_tr);
        for (int n = 1; n <= 7; n++) begin
            checks++;
            if (sel_tr[n] !== exp_sel[n] || en_tr[n] !== exp_en[n] || rv_tr[n] !== exp_rv[n] || re_tr[n] !== 1'b0) begin
                errors++; $display("FAIL b2b cycle %0d sel=%b en=%b rv=%b err=%b exp=%b/%b/%b/0",
                                   n, sel_tr[n], en_tr[n], rv_tr[n], re_tr[n], exp_sel[n], exp_en[n], exp_rv[n]);
            end
        end
        // Second command does not decode: one good response, then one error response.
        run_b2b(32'h9100_0000, sel_tr, en_tr, rv_tr, re_tr);
        nrsp = 0; last_err = 0;
        for (int n = 1; n <= 7; n++) begin
            if (rv_tr[n] === 1'b1) begin nrsp++; last_err = int'(re_tr[n]); end
        end
        checks++; if (nrsp !== 2 || last_err !== 1) begin
            errors++; $display("FAIL b2b_bad responses got=%0d last_err=%0d exp=2/1", nrsp, last_err);
        end
        checks++; if (sel_tr[3] !== 3'b000 || sel_tr[4] !== 3'b000 || rv_tr[3] !== 1'b1 || re_tr[3] !== 1'b0) begin
            errors++; $display("FAIL b2b_bad after first sel=%b/%b rv=%b err=%b exp=000/000/1/0", sel_tr[3], sel_tr[4], rv_tr[3], re_tr[3]);
        end
    endtask

    task automatic test_reset_mid();
        int seen, guard;
        seen = 0; guard = 0;
        @(posedge Hclk); #1;
        Pready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8400_0040;
        @(posedge Hclk); #1;
        cmd_valid = 1'b0;
        @(negedge Hclk);
        while (Penable !== 1'b1 && guard < 10) begin guard++; @(negedge Hclk); end
        checks++; if (Penable !== 1'b1) begin errors++; $display("FAIL reset_mid reach ACCESS got Penable=%b exp=1", Penable); end
        Hreset = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        @(negedge Hclk);
        checks++; if (Pselx !== 3'b000 || Penable !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid apb sel=%b en=%b ready=%b exp=000/0/1", Pselx, Penable, cmd_ready);
        end
        if (rsp_valid === 1'b1) seen++;
        for (int n = 0; n < 20; n++) begin
            @(negedge Hclk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid rsp_valid pulses got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wait_read();
        test_decode_error();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
